// File: rtl/mips_regfile.sv
// General-purpose register file: 32 GPRs plus HI/LO, two asynchronous read
// ports with same-cycle write-to-read forwarding and a single write port.
module mips_regfile #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter bit          BYPASS_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r1_en,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic              r2_en,
    input  logic [ADDR_W-1:0] r2_addr,
    output logic [DATA_W-1:0] r1_data,
    output logic [DATA_W-1:0] r2_data,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              hilo_we,
    input  logic [DATA_W-1:0] hi_wdata,
    input  logic [DATA_W-1:0] lo_wdata,
    output logic [DATA_W-1:0] hi_rdata,
    output logic [DATA_W-1:0] lo_rdata
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    // Flat register vector so reads stay asynchronous (no RAM inference).
    logic [NUM_REGS-1:0][DATA_W-1:0] gpr_q;
    logic [DATA_W-1:0]               hi_q;
    logic [DATA_W-1:0]               lo_q;

    // Forwarding hit when the current write targets the read index.
    logic w_live;
    assign w_live = BYPASS_EN && w_en && (w_addr != '0);

    // GPR and HI/LO state: synchronous clear, then writeback updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                gpr_q[i] <= '0;
            end
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            // r0 is hardwired; writes to it are dropped.
            if (w_en && (w_addr != '0)) begin
                gpr_q[w_addr] <= w_data;
            end
            if (hilo_we) begin
                hi_q <= hi_wdata;
                lo_q <= lo_wdata;
            end
        end
    end

    // Read port 1: reset, enable and r0 squash ahead of bypass and array.
    always_comb begin
        r1_data = '0;
        if (!rst && r1_en && (r1_addr != '0)) begin
            if (w_live && (w_addr == r1_addr)) begin
                r1_data = w_data;
            end else begin
                r1_data = gpr_q[r1_addr];
            end
        end
    end

    // Read port 2: identical rules, fully independent of port 1.
    always_comb begin
        r2_data = '0;
        if (!rst && r2_en && (r2_addr != '0)) begin
            if (w_live && (w_addr == r2_addr)) begin
                r2_data = w_data;
            end else begin
                r2_data = gpr_q[r2_addr];
            end
        end
    end

    // HI/LO reads: forward the pair being written this cycle.
    always_comb begin
        hi_rdata = '0;
        lo_rdata = '0;
        if (!rst) begin
            if (BYPASS_EN && hilo_we) begin
                hi_rdata = hi_wdata;
                lo_rdata = lo_wdata;
            end else begin
                hi_rdata = hi_q;
                lo_rdata = lo_q;
            end
        end
    end

endmodule

// File: tb/tb_mips_regfile.sv
// Bench for mips_regfile: directed scenarios plus randomized traffic against a
// array-based reference model, run on a forwarding and a non-forwarding copy.
module tb_mips_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        r1_en, r2_en, w_en, hilo_we;
    logic [4:0]  r1_addr, r2_addr, w_addr;
    logic [31:0] w_data, hi_wdata, lo_wdata;

    logic [31:0] r1_data, r2_data, hi_rdata, lo_rdata;
    logic [31:0] nb_r1_data, nb_r2_data, nb_hi_rdata, nb_lo_rdata;

    int checks = 0;
    int failures = 0;

    // Reference state: architectural register contents after the last edge.
    logic [31:0] m_gpr [32];
    logic [31:0] m_hi, m_lo;

    always #5 clk = ~clk;

    mips_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .r1_en(r1_en), .r1_addr(r1_addr), .r2_en(r2_en), .r2_addr(r2_addr),
        .r1_data(r1_data), .r2_data(r2_data),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
        .hi_rdata(hi_rdata), .lo_rdata(lo_rdata)
    );

    mips_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS_EN(1'b0)) dut_nb (
        .clk(clk), .rst(rst),
        .r1_en(r1_en), .r1_addr(r1_addr), .r2_en(r2_en), .r2_addr(r2_addr),
        .r1_data(nb_r1_data), .r2_data(nb_r2_data),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
        .hi_rdata(nb_hi_rdata), .lo_rdata(nb_lo_rdata)
    );

    // Expected GPR read value under the architectural read rules.
    function automatic logic [31:0] exp_rd(input bit byp, input logic en, input logic [4:0] a);
        if (rst || !en || a == 5'd0) return 32'h0;
        if (byp && w_en && w_addr == a) return w_data;
        return m_gpr[a];
    endfunction

    function automatic logic [63:0] exp_hilo(input bit byp);
        if (rst) return 64'h0;
        if (byp && hilo_we) return {hi_wdata, lo_wdata};
        return {m_hi, m_lo};
    endfunction

    // Advance one clock and apply the same edge to the reference model.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
            m_hi = 32'h0;
            m_lo = 32'h0;
        end else begin
            if (w_en && w_addr != 5'd0) m_gpr[w_addr] = w_data;
            if (hilo_we) begin
                m_hi = hi_wdata;
                m_lo = lo_wdata;
            end
        end
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; r1_en = 1'b0; r2_en = 1'b0; w_en = 1'b0; hilo_we = 1'b0;
        r1_addr = '0; r2_addr = '0; w_addr = '0;
        w_data = '0; hi_wdata = '0; lo_wdata = '0;
    endtask

    task automatic test_reset();
        idle();
        w_en = 1'b1; w_addr = 5'd5; w_data = 32'hDEADBEEF;
        tick();
        w_en = 1'b0; rst = 1'b1;
        r1_en = 1'b1; r1_addr = 5'd5; r2_en = 1'b1; r2_addr = 5'd5;
        #2;
        checks++;
        if ({r1_data, r2_data, hi_rdata, lo_rdata} !== 128'h0) begin
            failures++;
            $display("FAIL reset_held_en1 got %h %h %h %h want 0", r1_data, r2_data,
                     hi_rdata, lo_rdata);
        end
        // A write presented during reset must be lost.
        w_en = 1'b1; w_addr = 5'd6; w_data = 32'h11111111;
        r1_en = 1'b0; r2_en = 1'b1; r2_addr = 5'd6;
        #1;
        checks++;
        if ({r1_data, r2_data} !== 64'h0) begin
            failures++;
            $display("FAIL reset_held_mixed_en got %h %h want 0", r1_data, r2_data);
        end
        tick();
        rst = 1'b0; w_en = 1'b0; r1_en = 1'b1; r1_addr = 5'd5; r2_addr = 5'd6;
        #2;
        checks++;
        if ({r1_data, r2_data, hi_rdata, lo_rdata} !== 128'h0) begin
            failures++;
            $display("FAIL reset_cleared got %h %h %h %h want 0", r1_data, r2_data,
                     hi_rdata, lo_rdata);
        end
    endtask

    task automatic test_write_r0();
        idle();
        w_en = 1'b1; w_addr = 5'd7; w_data = 32'h12345678;
        tick();
        w_addr = 5'd0; w_data = 32'hFFFFFFFF;
        tick();
        w_en = 1'b0; r1_en = 1'b1; r1_addr = 5'd7; r2_en = 1'b1; r2_addr = 5'd0;
        #2;
        checks++;
        if (r1_data !== 32'h12345678 || nb_r1_data !== 32'h12345678) begin
            failures++;
            $display("FAIL readback_r7 got %h/%h want 12345678", r1_data, nb_r1_data);
        end
        checks++;
        if (r2_data !== 32'h0 || nb_r2_data !== 32'h0) begin
            failures++;
            $display("FAIL r0_zero got %h/%h want 00000000", r2_data, nb_r2_data);
        end
    endtask

    task automatic test_bypass();
        idle();
        w_en = 1'b1; w_addr = 5'd9; w_data = 32'hCAFEF00D;
        r1_en = 1'b1; r1_addr = 5'd9; r2_en = 1'b1; r2_addr = 5'd9;
        #2;
        checks++;
        if (r1_data !== 32'hCAFEF00D || r2_data !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL bypass_same_cycle got %h %h want cafef00d", r1_data, r2_data);
        end
        checks++;
        if (nb_r1_data !== 32'h0 || nb_r2_data !== 32'h0) begin
            failures++;
            $display("FAIL nobypass_old got %h %h want 00000000", nb_r1_data, nb_r2_data);
        end
        tick();
        w_en = 1'b0;
        #2;
        checks++;
        if (nb_r1_data !== 32'hCAFEF00D || nb_r2_data !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL nobypass_next got %h %h want cafef00d", nb_r1_data, nb_r2_data);
        end
    endtask

    task automatic test_enable_gating();
        idle();
        w_en = 1'b1; w_addr = 5'd3; w_data = 32'h00000055;
        tick();
        w_en = 1'b0; r1_en = 1'b0; r1_addr = 5'd3; r2_en = 1'b1; r2_addr = 5'd3;
        #2;
        checks++;
        if (r1_data !== 32'h0 || r2_data !== 32'h00000055) begin
            failures++;
            $display("FAIL enable_gating got %h %h want 00000000 00000055", r1_data, r2_data);
        end
    endtask

    task automatic test_hilo();
        idle();
        hilo_we = 1'b1; hi_wdata = 32'hA; lo_wdata = 32'hB;
        #2;
        checks++;
        if (hi_rdata !== 32'hA || lo_rdata !== 32'hB) begin
            failures++;
            $display("FAIL hilo_bypass got %h %h want a b", hi_rdata, lo_rdata);
        end
        checks++;
        if (nb_hi_rdata !== 32'h0 || nb_lo_rdata !== 32'h0) begin
            failures++;
            $display("FAIL hilo_nobypass got %h %h want 0 0", nb_hi_rdata, nb_lo_rdata);
        end
        tick();
        hilo_we = 1'b0; hi_wdata = 32'h77; lo_wdata = 32'h88;
        for (int c = 0; c < 3; c++) begin
            #2;
            checks++;
            if ({hi_rdata, lo_rdata, nb_hi_rdata, nb_lo_rdata} !== {4{32'h0}} + 128'h0000000A_0000000B_0000000A_0000000B) begin
                failures++;
                $display("FAIL hilo_hold cyc=%0d got %h %h %h %h want a b a b", c, hi_rdata,
                         lo_rdata, nb_hi_rdata, nb_lo_rdata);
            end
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #2;
        checks++;
        if ({hi_rdata, lo_rdata} !== 64'h0) begin
            failures++;
            $display("FAIL hilo_reset got %h %h want 0 0", hi_rdata, lo_rdata);
        end
    endtask

    task automatic test_back_to_back();
        idle();
        for (int i = 1; i < 32; i++) begin
            w_en = 1'b1; w_addr = 5'(i); w_data = i * 32'h01010101;
            tick();
        end
        w_en = 1'b0; r1_en = 1'b1; r2_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            r1_addr = 5'(i); r2_addr = 5'(31 - i);
            #1;
            checks++;
            if (r1_data !== i * 32'h01010101 || r2_data !== (31 - i) * 32'h01010101 ||
                nb_r1_data !== r1_data || nb_r2_data !== r2_data) begin
                failures++;
                $display("FAIL sweep idx=%0d got %h %h nb %h %h want %h %h", i, r1_data,
                         r2_data, nb_r1_data, nb_r2_data, i * 32'h01010101,
                         (31 - i) * 32'h01010101);
            end
        end
    endtask

    task automatic test_random();
        logic [127:0] e_byp, e_nb;
        for (int n = 0; n < 400; n++) begin
            rst      = ($urandom_range(31, 0) == 0);
            r1_en    = ($urandom_range(7, 0) != 0);
            r2_en    = ($urandom_range(7, 0) != 0);
            w_en     = ($urandom_range(3, 0) != 0);
            hilo_we  = ($urandom_range(3, 0) == 0);
            w_addr   = 5'($urandom_range(31, 0));
            // Bias reads toward the write index to exercise forwarding.
            r1_addr  = ($urandom_range(2, 0) == 0) ? w_addr : 5'($urandom_range(31, 0));
            r2_addr  = ($urandom_range(2, 0) == 0) ? w_addr : 5'($urandom_range(31, 0));
            w_data   = $urandom;
            hi_wdata = $urandom;
            lo_wdata = $urandom;
            #2;
            e_byp = {exp_rd(1'b1, r1_en, r1_addr), exp_rd(1'b1, r2_en, r2_addr), exp_hilo(1'b1)};
            e_nb  = {exp_rd(1'b0, r1_en, r1_addr), exp_rd(1'b0, r2_en, r2_addr), exp_hilo(1'b0)};
            checks++;
            if ({r1_data, r2_data, hi_rdata, lo_rdata} !== e_byp) begin
                failures++;
                $display("FAIL random_bypass n=%0d got %h want %h", n,
                         {r1_data, r2_data, hi_rdata, lo_rdata}, e_byp);
            end
            checks++;
            if ({nb_r1_data, nb_r2_data, nb_hi_rdata, nb_lo_rdata} !== e_nb) begin
                failures++;
                $display("FAIL random_nobypass n=%0d got %h want %h", n,
                         {nb_r1_data, nb_r2_data, nb_hi_rdata, nb_lo_rdata}, e_nb);
            end
            tick();
        end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        test_reset();
        test_write_r0();
        test_bypass();
        test_enable_gating();
        test_hilo();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
